// File: rtl/buf_sdp_pipe.sv
// buf_sdp_pipe: simple-dual-port buffer, byte-enable writes, RD_LAT-deep read pipe.
// Optional same-edge write-to-read bypass: define BUF_SDP_BYPASS_EN.
module buf_sdp_pipe #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wren,
  input  logic [ADDR_W-1:0]   wraddress,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] byteena,
  input  logic                rden,
  input  logic [ADDR_W-1:0]   rdaddress,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                wr_oob,
  output logic                rd_oob
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_in;
  logic              w_rd_in;
  logic [IW-1:0]     w_widx;
  logic [IW-1:0]     w_ridx;
  logic [DATA_W-1:0] w_rd_word;

  logic [RD_LAT-1:0] r_vld;
  logic [DATA_W-1:0] r_dat [RD_LAT];
  logic              r_wr_oob;
  logic              r_rd_oob;

  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  assign w_wr_in = {1'b0, wraddress} < (ADDR_W + 1)'(DEPTH);
  assign w_rd_in = {1'b0, rdaddress} < (ADDR_W + 1)'(DEPTH);
  assign w_widx  = wraddress[IW-1:0];
  assign w_ridx  = rdaddress[IW-1:0];

  always_ff @(posedge clock) begin
    if (wren && w_wr_in) begin
      for (int i = 0; i < NB; i++) begin
        if (byteena[i]) r_mem[w_widx][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in) w_rd_word = r_mem[w_ridx];
`ifdef BUF_SDP_BYPASS_EN
    if (w_rd_in && wren && (wraddress == rdaddress)) begin
      for (int i = 0; i < NB; i++) begin
        if (byteena[i]) w_rd_word[8*i +: 8] = data[8*i +: 8];
      end
    end
`endif
  end

  // data stages load only behind a valid, so q holds between strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_wr_oob <= 1'b0;
      r_rd_oob <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= rden;
      if (rden) r_dat[0] <= w_rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
      if (wren && !w_wr_in) r_wr_oob <= 1'b1;
      if (rden && !w_rd_in) r_rd_oob <= 1'b1;
    end
  end

  assign q       = r_dat[RD_LAT-1];
  assign q_valid = r_vld[RD_LAT-1];
  assign wr_oob  = r_wr_oob;
  assign rd_oob  = r_rd_oob;

endmodule

// File: tb/tb_buf_sdp_pipe.sv
// tb_buf_sdp_pipe: directed bench, three instances at RD_LAT 1/2/4.
// Expected data is hand-computed; BUF_SDP_BYPASS_EN selects collision results.
module tb_buf_sdp_pipe;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [9:0]  wraddress;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        rden;
  logic [9:0]  rdaddress;

  logic [31:0] q1, q2, q4;
  logic        v1, v2, v4;
  logic        wo1, wo2, wo4;
  logic        ro1, ro2, ro4;

  int n_chk;
  int n_fail;

  logic [9:0]  ra [16];
  logic [31:0] re [16];

  logic        cw_en;
  logic [9:0]  cw_addr;
  logic [31:0] cw_data;
  logic [3:0]  cw_be;

  buf_sdp_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(1)) u_l1 (
    .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress),
    .data(data), .byteena(byteena), .rden(rden), .rdaddress(rdaddress),
    .q(q1), .q_valid(v1), .wr_oob(wo1), .rd_oob(ro1)
  );

  buf_sdp_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) u_l2 (
    .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress),
    .data(data), .byteena(byteena), .rden(rden), .rdaddress(rdaddress),
    .q(q2), .q_valid(v2), .wr_oob(wo2), .rd_oob(ro2)
  );

  buf_sdp_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(4)) u_l4 (
    .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress),
    .data(data), .byteena(byteena), .rden(rden), .rdaddress(rdaddress),
    .q(q4), .q_valid(v4), .wr_oob(wo4), .rd_oob(ro4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    @(negedge clock);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    @(negedge clock);
    wren = 1'b0;
  endtask

  task automatic chk_lane(input string tag, input int lat, input int k,
                          input int n, input logic v, input logic [31:0] q);
    int j;
    j = k - lat;
    if (j >= 0 && j < n) begin
      check({tag, "_vld"}, {31'd0, v}, 32'd1);
      check({tag, "_q"}, q, re[j]);
    end else begin
      check({tag, "_idle"}, {31'd0, v}, 32'd0);
      if (j >= n) check({tag, "_hold"}, q, re[n-1]);
    end
  endtask

  // drives ra[0..n-1] back to back and checks every lane each cycle
  task automatic rd_seq(input int n);
    for (int k = 0; k < n + 6; k++) begin
      @(negedge clock);
      chk_lane("l1", 1, k, n, v1, q1);
      chk_lane("l2", 2, k, n, v2, q2);
      chk_lane("l4", 4, k, n, v4, q4);
      wren = (k == 0) && cw_en;
      wraddress = cw_addr; data = cw_data; byteena = cw_be;
      rden = (k < n);
      if (k < n) rdaddress = ra[k];
    end
    cw_en = 1'b0;
    wren  = 1'b0;
  endtask

  task automatic rd1(input logic [9:0] a, input logic [31:0] e);
    ra[0] = a; re[0] = e;
    rd_seq(1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_q1"}, q1, 32'd0);
    check({tag, "_q2"}, q2, 32'd0);
    check({tag, "_q4"}, q4, 32'd0);
    check({tag, "_v"}, {29'd0, v1, v2, v4}, 32'd0);
    check({tag, "_wo"}, {29'd0, wo1, wo2, wo4}, 32'd0);
    check({tag, "_ro"}, {29'd0, ro1, ro2, ro4}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; wren = 1'b0; rden = 1'b0;
    wraddress = '0; rdaddress = '0; data = '0; byteena = '0;
    cw_en = 1'b0; cw_addr = '0; cw_data = '0; cw_be = '0;
    repeat (2) @(negedge clock);
    chk_zero("rst");
    reset = 1'b0;

    wr(10'd3, 32'hA5A5_A5A5, 4'hF);
    rd1(10'd3, 32'hA5A5_A5A5);

    wr(10'd7, 32'hFFFF_FFFF, 4'hF);
    wr(10'd7, 32'h0000_0000, 4'h1);
    rd1(10'd7, 32'hFFFF_FF00);
    wr(10'd7, 32'h0000_0000, 4'h0);
    rd1(10'd7, 32'hFFFF_FF00);
    wr(10'd7, 32'h1234_5678, 4'hA);
    rd1(10'd7, 32'h12FF_5600);

    wr(10'd5, 32'h1111_1111, 4'hF);
    cw_en = 1'b1; cw_addr = 10'd5; cw_data = 32'h2222_2222; cw_be = 4'hF;
`ifdef BUF_SDP_BYPASS_EN
    rd1(10'd5, 32'h2222_2222);
`else
    rd1(10'd5, 32'h1111_1111);
`endif
    rd1(10'd5, 32'h2222_2222);

    wr(10'd6, 32'h1111_1111, 4'hF);
    cw_en = 1'b1; cw_addr = 10'd6; cw_data = 32'h3333_3333; cw_be = 4'h3;
`ifdef BUF_SDP_BYPASS_EN
    rd1(10'd6, 32'h1111_3333);
`else
    rd1(10'd6, 32'h1111_1111);
`endif
    rd1(10'd6, 32'h1111_3333);

    check("wo_pre", {29'd0, wo1, wo2, wo4}, 32'd0);
    wr(10'd999, 32'h0BAD_0999, 4'hF);
    check("wo_999", {29'd0, wo1, wo2, wo4}, 32'd0);
    wr(10'd1000, 32'hDEAD_BEEF, 4'hF);
    check("wo_set", {29'd0, wo1, wo2, wo4}, 32'd7);
    check("ro_pre", {29'd0, ro1, ro2, ro4}, 32'd0);
    rd1(10'd999, 32'h0BAD_0999);
    check("ro_999", {29'd0, ro1, ro2, ro4}, 32'd0);
    rd1(10'd1023, 32'd0);
    check("ro_set", {29'd0, ro1, ro2, ro4}, 32'd7);
    rd1(10'd1000, 32'd0);

    for (int i = 0; i < 16; i++) wr(10'(i), 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) begin
      ra[i] = 10'(i); re[i] = 32'(i);
    end
    rd_seq(16);
    check("wo_sticky", {29'd0, wo1, wo2, wo4}, 32'd7);
    check("ro_sticky", {29'd0, ro1, ro2, ro4}, 32'd7);

    wr(10'd7, 32'h12FF_5600, 4'hF);
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      if (k > 0) check("mid_v4", {31'd0, v4}, 32'd0);
      if (k == 4) chk_zero("mid_rst");
      rden = (k < 3);
      rdaddress = (k == 0) ? 10'd7 : (k == 1) ? 10'd15 : 10'd3;
      if (k == 2) reset = 1'b1;
      if (k == 6) reset = 1'b0;
    end
    rden = 1'b0;
    rd1(10'd7, 32'h12FF_5600);
    rd1(10'd15, 32'd15);
    check("post_wo", {29'd0, wo1, wo2, wo4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
